fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side drain engine for the asynchronous FIFO, in the read clock domain.
//  - Pops words through the FIFO read port (r_en / empty / read data).
//  - Re-presents them on a valid/ready output stream with a 2-entry prefetch buffer,
//    sustaining 1 word/cycle.
//  - Frames the stream into bursts of BURST_LEN beats, marked with m_last.
// PARAMETERS
//  DATA_WIDTH  8    width of FIFO read data and m_data
//  BURST_LEN   16   beats per burst; m_last asserted on the final beat (>=1)
// PORTS
//  clk          in   1           read-domain clock
//  r_rst        in   1           synchronous, active-high reset
//  rd_go        in   1           level; 1 = keep draining FIFO, 0 = stop and flush buffer
//  empty        in   1           FIFO empty flag (read domain)
//  fifo_rdata   in   DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted r_en
//  r_en         out  1           FIFO pop request
//  m_valid      out  1           output word valid
//  m_ready      in   1           downstream accepts when m_valid&&m_ready
//  m_data       out  DATA_WIDTH  output word
//  m_last       out  1           final beat of current burst (qualified by m_valid)
//  busy         out  1           state != IDLE
//  beat_count   out  32          accepted output beats (see CONFIGURATION)
//  starve_count out  16          RUN cycles starved by empty FIFO (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset
//  - One clock: clk. Synchronous active-high reset: r_rst.
//  - Reset values: r_en=0, m_valid=0, m_data=0, m_last=0, busy=0, both counters=0,
//    buffer count=0, inflight=0, beat index=0, state=IDLE.
//  - Reset mid-operation discards buffered and in-flight words; no recovery.
//  FIFO read timing
//  - Pop accepted when r_en && !empty.
//  - Popped word appears on fifo_rdata the next cycle. inflight=1 for that cycle;
//    the word is written into the buffer then.
//  Pop decision
//  - pop_out = m_valid && m_ready.
//  - r_en = (state==RUN) && !empty && (count + inflight - pop_out) < 2. Combinational
//    in m_ready, giving zero-bubble throughput.
//  - count + inflight never exceeds 2; a word is never dropped while m_ready is low.
//  Output stream
//  - m_valid = (count != 0). m_data = oldest buffered word.
//  - m_data is held stable while m_valid && !m_ready.
//  - Write and pop in the same cycle keep count unchanged; order is FIFO.
//  Burst framing
//  - Beat index increments on each pop_out and wraps to 0 after BURST_LEN-1.
//  - m_last = m_valid && (index == BURST_LEN-1).
//  - BURST_LEN=1 makes m_last high on every beat.
//  - Index is preserved across IDLE/DRAIN; cleared only by r_rst.
//  FSM (state in fifo_reader_pkg)
//  - IDLE:  r_en=0. rd_go=1 -> RUN.
//  - RUN:   pops enabled. rd_go=0 -> DRAIN.
//  - DRAIN: r_en=0; buffered/in-flight words still delivered.
//           rd_go=1 -> RUN; else count==0 && inflight==0 -> IDLE.
//  - empty=1 in RUN: stall in RUN, no state change.
// CONFIGURATION
//  - Macro READER_STATS_EN defined:
//    - beat_count increments on every pop_out, wraps at 2^32.
//    - starve_count increments each cycle with state==RUN && empty && count==0,
//      saturates at 16'hFFFF.
//    - Both clear on r_rst.
//  - Not defined: ports still exist, tied to 0, no counter logic.
// STRUCTURE
//  - fifo_reader_pkg holds:
//    - rd_state_e {IDLE, RUN, DRAIN}
//    - localparam SKID_DEPTH = 2
//    - width helper for beat index: $clog2(BURST_LEN) clamped to >=1
//  - Sub-module reader_skid_buf: 2-entry buffer with
//    wr_en/wr_data/rd_en/rd_data/count. Top keeps FSM, r_en logic, framing, stats.
// TESTING
//  - Reset: r_rst high 3 cycles mid-stream -> all outputs 0, state IDLE,
//    next rd_go starts from beat 0.
//  - Streaming: FIFO preloaded 0x00..0x1F, rd_go=1, m_ready=1 -> 32 beats back-to-back
//    with no gaps after 2-cycle fill; m_last on beats 15 and 31.
//  - Backpressure: m_ready toggles 1,0,0,1 random; 40 words -> exact in-order sequence,
//    m_data stable while stalled, r_en never asserted with count+inflight==2.
//  - Starvation: FIFO empties after word 5 for 10 cycles then refills -> m_valid drops
//    after beat 5, resumes with word 6, no duplicate.
//    With READER_STATS_EN, starve_count==10.
//  - Drain: rd_go falls with 2 words buffered, m_ready=1 -> no further r_en,
//    2 words delivered, IDLE 1 cycle after last pop, busy=0.
//  - BURST_LEN=1 build: 5 words -> m_last=1 on all 5 beats;
//    beat_count==5 with macro, 0 without.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_reader_pkg
// Shared types and constants for the FIFO read-side drain engine.
//   rd_state_e   : drain FSM state encoding (IDLE / RUN / DRAIN)
//   SKID_DEPTH   : entries in the output prefetch buffer
//   SKID_CNT_W   : width of the prefetch buffer occupancy count
//   idx_width()  : beat-index width for a burst length, never below 1 bit
// ---------------------------------------------------------------------------
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // A burst length of 1 still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned burst_len);
        return (burst_len <= 1) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// ---------------------------------------------------------------------------
// reader_skid_buf
// Two-entry in-order prefetch buffer between the FIFO read port and the
// output stream. A write and a read in the same cycle leave the count
// unchanged. Storage resets to zero so the read port shows 0 after reset.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   wr_en    in   store wr_data
//   wr_data  in   word to store
//   rd_en    in   retire the oldest word
//   rd_data  out  oldest stored word
//   count    out  number of stored words (0..SKID_DEPTH)
// ---------------------------------------------------------------------------
module reader_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [SKID_CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [SKID_CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + SKID_CNT_W'(wr_en) - SKID_CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-clock-domain drain engine for the asynchronous FIFO. Pops words via
// r_en/empty/fifo_rdata, re-presents them on a valid/ready stream through a
// 2-entry prefetch buffer at up to one word per cycle, and frames the stream
// into bursts of BURST_LEN beats marked by m_last.
// Optional feature macro: READER_STATS_EN enables beat_count/starve_count;
// when undefined both ports are tied to zero.
// Parameters:
//   DATA_WIDTH  data width of fifo_rdata / m_data
//   BURST_LEN   beats per burst (>= 1)
// Ports:
//   clk           in   read-domain clock
//   r_rst         in   synchronous active-high reset
//   rd_go         in   1 = keep draining, 0 = stop popping and flush buffer
//   empty         in   FIFO empty flag
//   fifo_rdata    in   FIFO read data, valid the cycle after an accepted pop
//   r_en          out  FIFO pop request
//   m_valid       out  output word valid
//   m_ready       in   downstream ready
//   m_data        out  output word (oldest buffered)
//   m_last        out  final beat of the current burst
//   busy          out  FSM not IDLE
//   beat_count    out  accepted output beats (stats build)
//   starve_count  out  RUN cycles starved by an empty FIFO (stats build)
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  r_rst,
    input  logic                  rd_go,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [31:0]           beat_count,
    output logic [15:0]           starve_count
);

    localparam int unsigned     IDX_W    = idx_width(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    rd_state_e             state_q, state_d;
    logic                  inflight_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SKID_CNT_W-1:0] buf_count;
    logic                  pop_out;
    logic [2:0]            occ_after;

    assign m_valid = (buf_count != '0);
    assign pop_out = m_valid && m_ready;
    assign m_last  = m_valid && (idx_q == LAST_IDX);

    // Occupancy after this cycle's output pop; a word leaving frees a slot
    // in the same cycle, which keeps the stream bubble-free.
    assign occ_after = 3'(buf_count) + 3'(inflight_q) - 3'(pop_out);

    reader_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (r_rst),
        .wr_en   (inflight_q),
        .wr_data (fifo_rdata),
        .rd_en   (pop_out),
        .rd_data (m_data),
        .count   (buf_count)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (r_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rd_go) state_d = RUN;
            RUN:     if (!rd_go) state_d = DRAIN;
            DRAIN: begin
                if (rd_go)
                    state_d = RUN;
                else if (buf_count == '0 && !inflight_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
        r_en = (state_q == RUN) && !empty && (occ_after < 3'd2);
    end

    always_comb begin
        idx_d = idx_q;
        if (pop_out) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (r_rst) begin
            inflight_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            inflight_q <= r_en;   // r_en already implies !empty
            idx_q      <= idx_d;
        end
    end

`ifdef READER_STATS_EN
    logic [31:0] beat_q,   beat_d;
    logic [15:0] starve_q, starve_d;

    always_comb begin
        beat_d   = beat_q;
        starve_d = starve_q;
        if (pop_out) beat_d = beat_q + 32'd1;
        if (state_q == RUN && empty && buf_count == '0 && starve_q != 16'hFFFF)
            starve_d = starve_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (r_rst) begin
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    assign beat_count   = beat_q;
    assign starve_count = starve_q;
`else
    assign beat_count   = '0;
    assign starve_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int BL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0: BURST_LEN = 16 ----------------
    logic        r_rst = 1'b1;
    logic        rd_go = 1'b0;
    logic        empty;
    logic [7:0]  fifo_rdata = '0;
    logic        r_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [31:0] beat_count;
    logic [15:0] starve_count;

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .r_rst        (r_rst),
        .rd_go        (rd_go),
        .empty        (empty),
        .fifo_rdata   (fifo_rdata),
        .r_en         (r_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .beat_count   (beat_count),
        .starve_count (starve_count)
    );

    // FIFO read-port model for DUT 0
    logic [7:0] fmem [0:1023];
    int f_wr = 0;
    int f_rd = 0;
    assign empty = (f_rd == f_wr);
    always @(posedge clk) begin
        if (r_en && !empty) begin
            fifo_rdata <= fmem[f_rd];
            f_rd       <= f_rd + 1;
        end
    end

    // ---------------- DUT 1: BURST_LEN = 1 ----------------
    logic        rd_go1 = 1'b0;
    logic        empty1;
    logic [7:0]  fifo_rdata1 = '0;
    logic        r_en1;
    logic        m_valid1;
    logic        m_ready1 = 1'b0;
    logic [7:0]  m_data1;
    logic        m_last1;
    logic        busy1;
    logic [31:0] beat_count1;
    logic [15:0] starve_count1;

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .BURST_LEN  (1)
    ) dut1 (
        .clk          (clk),
        .r_rst        (r_rst),
        .rd_go        (rd_go1),
        .empty        (empty1),
        .fifo_rdata   (fifo_rdata1),
        .r_en         (r_en1),
        .m_valid      (m_valid1),
        .m_ready      (m_ready1),
        .m_data       (m_data1),
        .m_last       (m_last1),
        .busy         (busy1),
        .beat_count   (beat_count1),
        .starve_count (starve_count1)
    );

    logic [7:0] fmem1 [0:63];
    int f_wr1 = 0;
    int f_rd1 = 0;
    assign empty1 = (f_rd1 == f_wr1);
    always @(posedge clk) begin
        if (r_en1 && !empty1) begin
            fifo_rdata1 <= fmem1[f_rd1];
            f_rd1       <= f_rd1 + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int bidx = 0;           // expected burst beat index
    int hs_since_rst = 0;   // accepted beats since the last reset

    task automatic push(input logic [7:0] v);
        fmem[f_wr] = v;
        f_wr++;
    endtask

    task automatic push1(input logic [7:0] v);
        fmem1[f_wr1] = v;
        f_wr1++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rd_go = 1'b0; rd_go1 = 1'b0; m_ready = 1'b0; m_ready1 = 1'b0;
        r_rst = 1'b1;
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        f_wr = f_rd; f_wr1 = f_rd1;
        bidx = 0; hs_since_rst = 0;
    endtask

    // Drops rd_go and waits (bounded) for busy to fall.
    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        rd_go = 1'b0;
        #1;
        while (busy && k < 20) begin
            @(negedge clk); #1; k++;
        end
        ok = !busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        r_rst = 1'b1; rd_go = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({r_en, m_valid, m_last, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 0000", {r_en, m_valid, m_last, busy});
        end
        n_cmp++;
        if (m_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data: got %0h expected 0", m_data);
        end
        n_cmp++;
        if (beat_count !== 32'd0 || starve_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", beat_count, starve_count);
        end
        r_rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || r_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: busy=%b r_en=%b expected 0/0", busy, r_en);
        end
    endtask

    task automatic test_streaming();
        int hs, first, gaps, cyc;
        bit ok;
        logic exp_last;
        hs = 0; first = -1; gaps = 0; cyc = 0;
        for (int i = 0; i < 32; i++) push(8'(i));
        @(negedge clk);
        rd_go = 1'b1; m_ready = 1'b1;
        while (hs < 32 && cyc < 80) begin
            @(negedge clk); #1; cyc++;
            if (m_valid) begin
                if (first < 0) first = cyc;
            end else if (first >= 0) begin
                gaps++;
            end
            if (m_valid && m_ready) begin
                exp_last = (bidx == BL - 1);
                n_cmp++;
                if (m_data !== 8'(hs)) begin
                    n_bad++; $display("FAIL stream_data: beat %0d got %0h expected %0h", hs, m_data, 8'(hs));
                end
                n_cmp++;
                if (m_last !== exp_last) begin
                    n_bad++; $display("FAIL stream_last: beat %0d got %b expected %b", hs, m_last, exp_last);
                end
                hs++; hs_since_rst++; bidx = (bidx + 1) % BL;
            end
        end
        n_cmp++;
        if (hs != 32) begin
            n_bad++; $display("FAIL stream_count: got %0d beats expected 32", hs);
        end
        n_cmp++;
        if (first != 3) begin
            n_bad++; $display("FAIL stream_latency: first valid at cycle %0d expected 3", first);
        end
        n_cmp++;
        if (gaps != 0) begin
            n_bad++; $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL stream_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int hs, cyc, rd_base, occ;
        bit ok, stalled_prev;
        logic [7:0] prev_data;
        logic [3:0] pat;
        logic exp_last;
        hs = 0; cyc = 0; stalled_prev = 1'b0; prev_data = '0;
        pat = 4'b1001;
        rd_base = f_rd;
        for (int i = 0; i < 40; i++) push(8'(8'h80 + i));
        @(negedge clk);
        rd_go = 1'b1;
        while (hs < 40 && cyc < 400) begin
            @(negedge clk);
            m_ready = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
            #1; cyc++;
            if (stalled_prev) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    n_bad++; $display("FAIL bp_stable: valid=%b data=%0h expected 1/%0h", m_valid, m_data, prev_data);
                end
            end
            occ = (f_rd - rd_base) - hs;
            n_cmp++;
            if (occ > 2) begin
                n_bad++; $display("FAIL bp_occupancy: got %0d expected <=2", occ);
            end
            if (r_en) begin
                n_cmp++;
                if (occ >= 2 && !(m_valid && m_ready)) begin
                    n_bad++; $display("FAIL bp_r_en_full: r_en=1 with occupancy %0d and no pop", occ);
                end
            end
            if (m_valid && m_ready) begin
                exp_last = (bidx == BL - 1);
                n_cmp++;
                if (m_data !== 8'(8'h80 + hs)) begin
                    n_bad++; $display("FAIL bp_data: beat %0d got %0h expected %0h", hs, m_data, 8'(8'h80 + hs));
                end
                n_cmp++;
                if (m_last !== exp_last) begin
                    n_bad++; $display("FAIL bp_last: beat %0d got %b expected %b", hs, m_last, exp_last);
                end
                hs++; hs_since_rst++; bidx = (bidx + 1) % BL;
            end
            stalled_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
        n_cmp++;
        if (hs != 40) begin
            n_bad++; $display("FAIL bp_count: got %0d beats expected 40", hs);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL bp_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_starvation();
        int hs, cyc, starved, hs_at_starve;
        bit ok, refilled;
        logic [15:0] snap;
        logic exp_last;
        hs = 0; cyc = 0; starved = 0; hs_at_starve = -1; refilled = 1'b0; snap = '0;
        pulse_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        @(negedge clk);
        rd_go = 1'b1; m_ready = 1'b1;
        while (hs < 12 && cyc < 200) begin
            @(negedge clk);
            if (!refilled && starved == 10) begin
                for (int i = 6; i < 12; i++) push(8'(8'h10 + i));
                refilled = 1'b1;
            end
            #1; cyc++;
            if (!refilled && busy && empty && !m_valid) begin
                if (starved == 0) hs_at_starve = hs;
                starved++;
            end
            if (m_valid && m_ready) begin
                exp_last = (bidx == BL - 1);
                n_cmp++;
                if (m_data !== 8'(8'h10 + hs)) begin
                    n_bad++; $display("FAIL starve_data: beat %0d got %0h expected %0h", hs, m_data, 8'(8'h10 + hs));
                end
                n_cmp++;
                if (m_last !== exp_last) begin
                    n_bad++; $display("FAIL starve_last: beat %0d got %b expected %b", hs, m_last, exp_last);
                end
                hs++; hs_since_rst++; bidx = (bidx + 1) % BL;
                if (hs == 12) snap = starve_count;
            end
        end
        n_cmp++;
        if (hs != 12) begin
            n_bad++; $display("FAIL starve_count_beats: got %0d beats expected 12", hs);
        end
        n_cmp++;
        if (starved != 10 || hs_at_starve != 6) begin
            n_bad++; $display("FAIL starve_gap: starved %0d cycles after beat %0d, expected 10 after 6", starved, hs_at_starve);
        end
`ifdef READER_STATS_EN
        n_cmp++;
        if (snap !== 16'd10) begin
            n_bad++; $display("FAIL starve_stat: got %0d expected 10", snap);
        end
`else
        n_cmp++;
        if (snap !== 16'd0) begin
            n_bad++; $display("FAIL starve_stat: got %0d expected 0", snap);
        end
`endif
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL starve_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_drain();
        int hs, rd_base;
        logic exp_last;
        hs = 0;
        m_ready = 1'b0;
        rd_base = f_rd;
        for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
        @(negedge clk);
        rd_go = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_cmp++;
        if (f_rd - rd_base != 2 || m_valid !== 1'b1) begin
            n_bad++; $display("FAIL drain_fill: popped %0d valid=%b expected 2/1", f_rd - rd_base, m_valid);
        end
        @(negedge clk);
        rd_go = 1'b0;
        #1;
        n_cmp++;
        if (r_en !== 1'b0) begin
            n_bad++; $display("FAIL drain_r_en_fall: got %b expected 0", r_en);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            n_cmp++;
            if (r_en !== 1'b0) begin
                n_bad++; $display("FAIL drain_r_en: cycle %0d got %b expected 0", j, r_en);
            end
            if (m_valid && m_ready) begin
                exp_last = (bidx == BL - 1);
                n_cmp++;
                if (m_data !== 8'(8'h30 + hs) || m_last !== exp_last) begin
                    n_bad++; $display("FAIL drain_data: beat %0d got %0h/%b expected %0h/%b", hs, m_data, m_last, 8'(8'h30 + hs), exp_last);
                end
                hs++; hs_since_rst++; bidx = (bidx + 1) % BL;
            end
        end
        n_cmp++;
        if (hs != 2 || f_rd - rd_base != 2) begin
            n_bad++; $display("FAIL drain_count: delivered %0d popped %0d expected 2/2", hs, f_rd - rd_base);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL drain_idle: busy=%b expected 0", busy);
        end
        f_wr = f_rd;
    endtask

    task automatic test_stats();
`ifdef READER_STATS_EN
        n_cmp++;
        if (beat_count !== 32'(hs_since_rst)) begin
            n_bad++; $display("FAIL stats_beats: got %0d expected %0d", beat_count, hs_since_rst);
        end
`else
        n_cmp++;
        if (beat_count !== 32'd0 || starve_count !== 16'd0) begin
            n_bad++; $display("FAIL stats_tied: got %0d/%0d expected 0/0", beat_count, starve_count);
        end
`endif
    endtask

    task automatic test_burst1();
        int hs, cyc;
        hs = 0; cyc = 0;
        for (int i = 0; i < 5; i++) push1(8'(8'hE0 + i));
        @(negedge clk);
        rd_go1 = 1'b1; m_ready1 = 1'b1;
        while (hs < 5 && cyc < 40) begin
            @(negedge clk); #1; cyc++;
            if (m_valid1 && m_ready1) begin
                n_cmp++;
                if (m_data1 !== 8'(8'hE0 + hs) || m_last1 !== 1'b1) begin
                    n_bad++; $display("FAIL burst1_beat: beat %0d got %0h/%b expected %0h/1", hs, m_data1, m_last1, 8'(8'hE0 + hs));
                end
                hs++;
            end
        end
        n_cmp++;
        if (hs != 5) begin
            n_bad++; $display("FAIL burst1_count: got %0d beats expected 5", hs);
        end
`ifdef READER_STATS_EN
        n_cmp++;
        if (beat_count1 !== 32'd5) begin
            n_bad++; $display("FAIL burst1_stat: got %0d expected 5", beat_count1);
        end
`else
        n_cmp++;
        if (beat_count1 !== 32'd0) begin
            n_bad++; $display("FAIL burst1_stat: got %0d expected 0", beat_count1);
        end
`endif
        @(negedge clk);
        rd_go1 = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int hs, cyc;
        bit ok;
        logic exp_last;
        hs = 0; cyc = 0;
        for (int i = 0; i < 20; i++) push(8'(8'h50 + i));
        @(negedge clk);
        rd_go = 1'b1; m_ready = 1'b1;
        while (hs < 5 && cyc < 40) begin
            @(negedge clk); #1; cyc++;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (m_data !== 8'(8'h50 + hs)) begin
                    n_bad++; $display("FAIL mid_pre_data: beat %0d got %0h expected %0h", hs, m_data, 8'(8'h50 + hs));
                end
                hs++;
            end
        end
        // Reset lands while words are buffered and in flight.
        r_rst = 1'b1; rd_go = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({r_en, m_valid, m_last, busy} !== 4'b0000 || m_data !== 8'h00) begin
            n_bad++; $display("FAIL mid_reset_outputs: flags=%b data=%0h expected 0000/0", {r_en, m_valid, m_last, busy}, m_data);
        end
        n_cmp++;
        if (beat_count !== 32'd0 || starve_count !== 16'd0) begin
            n_bad++; $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", beat_count, starve_count);
        end
        r_rst = 1'b0;
        f_wr = f_rd; bidx = 0; hs_since_rst = 0;
        hs = 0; cyc = 0;
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        @(negedge clk);
        rd_go = 1'b1;
        while (hs < 16 && cyc < 60) begin
            @(negedge clk); #1; cyc++;
            if (m_valid && m_ready) begin
                exp_last = (hs == 15);
                n_cmp++;
                if (m_data !== 8'(8'h60 + hs) || m_last !== exp_last) begin
                    n_bad++; $display("FAIL mid_post_beat: beat %0d got %0h/%b expected %0h/%b", hs, m_data, m_last, 8'(8'h60 + hs), exp_last);
                end
                hs++;
            end
        end
        n_cmp++;
        if (hs != 16) begin
            n_bad++; $display("FAIL mid_post_count: got %0d beats expected 16", hs);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL mid_idle: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_starvation();
        test_drain();
        test_stats();
        test_burst1();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
